// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, ALU/jump opcodes and multiplier FSM states
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam int PC_W = 5;
  localparam int REG_W = 5;
  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR = 5'd3;
  localparam logic [4:0] ALU_XOR = 5'd4;
  localparam logic [4:0] ALU_SLL = 5'd5;
  localparam logic [4:0] ALU_SRL = 5'd6;
  localparam logic [4:0] ALU_SRA = 5'd7;
  localparam logic [4:0] ALU_SLT = 5'd8;
  localparam logic [4:0] ALU_SLTU = 5'd9;
  localparam logic [4:0] ALU_MUL = 5'd10;
  localparam logic [4:0] ALU_PASSB = 5'd11;
  localparam logic [3:0] JMP_NONE = 4'd0;
  localparam logic [3:0] JMP_JMP = 4'd1;
  localparam logic [3:0] JMP_BEQ = 4'd2;
  localparam logic [3:0] JMP_BNE = 4'd3;
  localparam logic [3:0] JMP_BLT = 4'd4;
  localparam logic [3:0] JMP_BGE = 4'd5;
  localparam logic [3:0] JMP_JR = 4'd6;
  typedef enum logic {IDLE, BUSY} mul_state_t;
endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-add multiplier (start/a/b in; busy/done/product out), one operand bit per cycle
module seq_multiplier
  import cpu_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);
  localparam int CW = $clog2(MUL_CYCLES) + 1;
  mul_state_t state, state_n;
  logic [DATA_W-1:0] a_q, b_q, acc, b_sh, partial;
  logic [CW-1:0] count;
  assign b_sh = b_q >> count;
  assign partial = b_sh[0] ? a_q << count : '0;
  assign product = acc + partial;
  assign busy = state == BUSY;
  assign done = busy && count == CW'(MUL_CYCLES - 1);
  always_comb state_n = state == IDLE ? (start ? BUSY : IDLE) : (done ? IDLE : BUSY);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        a_q <= a;
        b_q <= b;
        acc <= '0;
        count <= '0;
      end else if (busy) begin
        acc <= product;
        count <= count + 1'b1;
      end
    end
  end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage with ALU, branch resolve, sequential multiply and EX/MEM registers
module ex_stage
  import cpu_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_halt,
  input  logic [DATA_W-1:0] in_rd1,
  input  logic [DATA_W-1:0] in_rd2,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_alu_src,
  input  logic [4:0]        in_alu_op,
  input  logic [3:0]        in_jmp_type,
  input  logic              in_reg_wrenable,
  input  logic              in_mem_wrenable,
  input  logic              in_mem_to_reg,
  input  logic [REG_W-1:0]  in_write_reg,
  output logic              out_stall,
  output logic              out_take_jump,
  output logic [PC_W-1:0]   out_jump_target,
  output logic              out_flush,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_W-1:0]  out_write_reg,
  output logic              out_reg_wrenable,
  output logic              out_mem_wrenable,
  output logic              out_mem_to_reg,
  output logic              out_halt
);
  logic [DATA_W-1:0] a, b, alu, mul_product;
  logic is_mul, mul_busy, mul_done, cond, bubble;
  assign a = in_rd1;
  assign b = in_alu_src ? in_imm : in_rd2;
  assign is_mul = in_alu_op == ALU_MUL;
  seq_multiplier #(.MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk(clk),
    .reset(reset),
    .start(is_mul),
    .a(a),
    .b(b),
    .busy(mul_busy),
    .done(mul_done),
    .product(mul_product)
  );
  assign out_stall = mul_busy ? !mul_done : is_mul;
  always_comb begin
    case (in_alu_op)
      ALU_ADD: alu = a + b;
      ALU_SUB: alu = a - b;
      ALU_AND: alu = a & b;
      ALU_OR: alu = a | b;
      ALU_XOR: alu = a ^ b;
      ALU_SLL: alu = a << b[4:0];
      ALU_SRL: alu = a >> b[4:0];
      ALU_SRA: alu = $signed(a) >>> b[4:0];
      ALU_SLT: alu = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: alu = {{(DATA_W-1){1'b0}}, a < b};
      ALU_MUL: alu = mul_product;
      ALU_PASSB: alu = b;
      default: alu = '0;
    endcase
  end
  always_comb begin
    case (in_jmp_type)
      JMP_JMP, JMP_JR: cond = 1'b1;
      JMP_BEQ: cond = in_rd1 == in_rd2;
      JMP_BNE: cond = in_rd1 != in_rd2;
      JMP_BLT: cond = $signed(in_rd1) < $signed(in_rd2);
      JMP_BGE: cond = $signed(in_rd1) >= $signed(in_rd2);
      default: cond = 1'b0;
    endcase
  end
  assign out_take_jump = cond && !out_halt;
  assign out_flush = out_take_jump;
  assign out_jump_target = in_jmp_type == JMP_JR ? in_rd1[PC_W-1:0] : in_pc + in_imm[PC_W-1:0];
  assign bubble = out_stall || out_halt;
  always_ff @(posedge clk) begin
    if (reset) begin
      out_alu_result <= '0;
      out_store_data <= '0;
      out_write_reg <= '0;
      out_reg_wrenable <= 1'b0;
      out_mem_wrenable <= 1'b0;
      out_mem_to_reg <= 1'b0;
      out_halt <= 1'b0;
    end else begin
      out_alu_result <= alu;
      out_store_data <= in_rd2;
      out_write_reg <= in_write_reg;
      out_reg_wrenable <= in_reg_wrenable && !bubble;
      out_mem_wrenable <= in_mem_wrenable && !bubble;
      out_mem_to_reg <= in_mem_to_reg && !bubble;
      out_halt <= out_halt || (in_halt && !out_stall);
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed scoreboard bench for ex_stage
module tb_ex_stage;
  logic clk = 0, reset = 1;
  logic [4:0] in_pc = '0, in_alu_op = '0, in_write_reg = '0;
  logic in_halt = 0, in_alu_src = 0, in_reg_wrenable = 0, in_mem_wrenable = 0, in_mem_to_reg = 0;
  logic [31:0] in_rd1 = '0, in_rd2 = '0, in_imm = '0;
  logic [3:0] in_jmp_type = '0;
  logic out_stall, out_take_jump, out_flush, out_reg_wrenable, out_mem_wrenable, out_mem_to_reg, out_halt;
  logic [4:0] out_jump_target, out_write_reg;
  logic [31:0] out_alu_result, out_store_data;
  int checks = 0, errors = 0, cyc = 0, t0;
  typedef struct {
    logic [31:0] res;
    logic [31:0] store;
    logic [4:0] wr;
    logic rwe;
    logic res_valid;
  } exp_t;
  exp_t q[$];
  ex_stage dut (
    .clk(clk), .reset(reset), .in_pc(in_pc), .in_halt(in_halt), .in_rd1(in_rd1), .in_rd2(in_rd2),
    .in_imm(in_imm), .in_alu_src(in_alu_src), .in_alu_op(in_alu_op), .in_jmp_type(in_jmp_type),
    .in_reg_wrenable(in_reg_wrenable), .in_mem_wrenable(in_mem_wrenable), .in_mem_to_reg(in_mem_to_reg),
    .in_write_reg(in_write_reg), .out_stall(out_stall), .out_take_jump(out_take_jump),
    .out_jump_target(out_jump_target), .out_flush(out_flush), .out_alu_result(out_alu_result),
    .out_store_data(out_store_data), .out_write_reg(out_write_reg), .out_reg_wrenable(out_reg_wrenable),
    .out_mem_wrenable(out_mem_wrenable), .out_mem_to_reg(out_mem_to_reg), .out_halt(out_halt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [4:0] op, input logic [31:0] rd1, rd2, imm, input logic src,
                       input logic [3:0] jt, input logic [4:0] pc, input logic halt, rwe,
                       input logic [4:0] wr, input logic [31:0] res, input logic res_valid, exp_rwe);
    in_alu_op = op; in_rd1 = rd1; in_rd2 = rd2; in_imm = imm; in_alu_src = src;
    in_jmp_type = jt; in_pc = pc; in_halt = halt; in_reg_wrenable = rwe; in_write_reg = wr;
    q.push_back('{res: res, store: rd2, wr: wr, rwe: exp_rwe, res_valid: res_valid});
  endtask
  task automatic exec(input string tag, input int exp_stall);
    int n = 0;
    exp_t e;
    #2;
    while (out_stall && n < 100) begin
      n++;
      @(posedge clk); #1;
      chk({tag, "_bubble"}, 32'(out_reg_wrenable), 32'd0);
      #2;
    end
    chk({tag, "_stall_cycles"}, n, exp_stall);
    @(posedge clk); #1;
    e = q.pop_front();
    if (e.res_valid) chk({tag, "_result"}, out_alu_result, e.res);
    chk({tag, "_store"}, out_store_data, e.store);
    chk({tag, "_wr"}, 32'(out_write_reg), 32'(e.wr));
    chk({tag, "_rwe"}, 32'(out_reg_wrenable), 32'(e.rwe));
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst_result", out_alu_result, 0);
    chk("rst_rwe", 32'(out_reg_wrenable), 0);
    chk("rst_halt", 32'(out_halt), 0);
    chk("rst_stall", 32'(out_stall), 0);
    issue(5'd0, 5, 32'h55, -32'sd3, 1, 4'd0, 0, 0, 1, 7, 2, 1, 1);
    exec("add", 0);
    issue(5'd1, 32'h800000F0, 32'h34, 0, 0, 4'd0, 0, 0, 1, 1, 32'h800000BC, 1, 1); exec("sub", 0);
    issue(5'd2, 32'h800000F0, 32'h34, 0, 0, 4'd0, 0, 0, 1, 2, 32'h00000030, 1, 1); exec("and", 0);
    issue(5'd3, 32'h800000F0, 32'h34, 0, 0, 4'd0, 0, 0, 1, 3, 32'h800000F4, 1, 1); exec("or", 0);
    issue(5'd4, 32'h800000F0, 32'h34, 0, 0, 4'd0, 0, 0, 1, 4, 32'h800000C4, 1, 1); exec("xor", 0);
    issue(5'd5, 32'h800000F0, 32'h34, 0, 0, 4'd0, 0, 0, 1, 5, 32'h0F000000, 1, 1); exec("sll", 0);
    issue(5'd6, 32'h800000F0, 32'h34, 0, 0, 4'd0, 0, 0, 1, 6, 32'h00000800, 1, 1); exec("srl", 0);
    issue(5'd7, 32'h800000F0, 32'h34, 0, 0, 4'd0, 0, 0, 1, 7, 32'hFFFFF800, 1, 1); exec("sra", 0);
    issue(5'd8, 32'h800000F0, 32'h34, 0, 0, 4'd0, 0, 0, 1, 8, 32'h1, 1, 1); exec("slt", 0);
    issue(5'd9, 32'h800000F0, 32'h34, 0, 0, 4'd0, 0, 0, 1, 9, 32'h0, 1, 1); exec("sltu", 0);
    issue(5'd11, 32'h800000F0, 32'h34, 0, 0, 4'd0, 0, 0, 1, 10, 32'h34, 1, 1); exec("passb", 0);
    issue(5'd15, 32'h800000F0, 32'h34, 0, 0, 4'd0, 0, 0, 1, 11, 32'h0, 1, 1); exec("op15", 0);
    issue(5'd0, 9, 9, 4, 0, 4'd2, 30, 0, 0, 0, 18, 1, 0);
    #2;
    chk("beq_take", 32'(out_take_jump), 1);
    chk("beq_flush", 32'(out_flush), 1);
    chk("beq_target", 32'(out_jump_target), 2);
    exec("beq", 0);
    issue(5'd0, 9, 9, 4, 0, 4'd3, 30, 0, 0, 0, 18, 1, 0);
    #2;
    chk("bne_take", 32'(out_take_jump), 0);
    chk("bne_flush", 32'(out_flush), 0);
    exec("bne", 0);
    issue(5'd10, 32'hFFFFFFFF, 3, 0, 0, 4'd0, 0, 0, 1, 3, 32'hFFFFFFFD, 1, 1);
    exec("mul_neg", 32);
    t0 = cyc;
    issue(5'd10, 1234, 5678, 0, 0, 4'd0, 0, 0, 1, 12, 7006652, 1, 1);
    exec("mul_a", 32);
    issue(5'd10, 1234, 5678, 0, 0, 4'd0, 0, 0, 1, 13, 7006652, 1, 1);
    exec("mul_b", 32);
    chk("mul_b2b_cycles", cyc - t0, 66);
    in_alu_op = 5'd10; in_rd1 = 7; in_rd2 = 9; in_reg_wrenable = 1; in_write_reg = 14;
    repeat (10) @(posedge clk);
    #1;
    chk("pre_reset_stall", 32'(out_stall), 1);
    reset = 1;
    issue(5'd1, 3, 5, 0, 0, 4'd0, 0, 0, 1, 15, 32'hFFFFFFFE, 1, 1);
    @(posedge clk); #1;
    reset = 0;
    chk("mrst_result", out_alu_result, 0);
    chk("mrst_store", out_store_data, 0);
    chk("mrst_rwe", 32'(out_reg_wrenable), 0);
    chk("mrst_wr", 32'(out_write_reg), 0);
    chk("mrst_stall", 32'(out_stall), 0);
    exec("sub_after_reset", 0);
    issue(5'd0, 0, 0, 2, 1, 4'd1, 3, 1, 0, 0, 2, 1, 0);
    #2;
    chk("halt_jmp_take", 32'(out_take_jump), 1);
    chk("halt_jmp_target", 32'(out_jump_target), 5);
    exec("halt_jmp", 0);
    chk("halt_set", 32'(out_halt), 1);
    chk("halt_take_suppressed", 32'(out_take_jump), 0);
    issue(5'd0, 1, 0, 1, 1, 4'd0, 0, 0, 1, 16, 2, 0, 0);
    exec("add_halted", 0);
    issue(5'd0, 4, 0, 1, 1, 4'd0, 0, 0, 1, 17, 5, 0, 0);
    exec("add_halted2", 0);
    chk("halt_sticky", 32'(out_halt), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
